// File: rtl/bin2bcd_seq.sv
`timescale 1ns/1ps
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter.
// Takes one input bit per clock. A request is accepted through a valid/ready
// handshake. Each finished result is marked by a one-cycle out_valid strobe,
// and the result then stays stable until the next conversion completes.
// If the input is >= 10^DIGITS, the output saturates to all nines and
// overflow is set.
// Optional: define BIN2BCD_BLANK_EN to generate the leading-zero blanking
// mask. Without it, blank is tied low.
module bin2bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BIN_W-1:0]      bin,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  out_valid,
    output logic                  overflow,
    output logic [DIGITS-1:0]     blank
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    localparam longint unsigned LIMIT = pow10(DIGITS);
    localparam logic [BCD_W-1:0] SAT  = {DIGITS{4'h9}};

    typedef enum logic [0:0] {IDLE, SHIFT} state_t;

    state_t             state;
    logic [BIN_W-1:0]   shift_reg;
    logic [BCD_W-1:0]   bcd_work;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_work;
    logic [BCD_W-1:0]   adj_work;
    logic [BCD_W-1:0]   next_work;

    assign in_ready = (state == IDLE);

    // Add-3 correction of every nibble, then the shifted working value.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        adj_work = bcd_work;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_work[4*i +: 4] >= 4'd5)
                adj_work[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
        end
        next_work = {adj_work[BCD_W-2:0], shift_reg[BIN_W-1]};
    end

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank_next;

    // Leading-zero mask: digit i is blanked while it and all higher digits are zero.
    always_comb begin
        logic all_zero;
        blank_next = '0;
        all_zero   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero      = all_zero && (next_work[4*i +: 4] == 4'd0);
            blank_next[i] = all_zero;
        end
    end
`else
    assign blank = '0;
`endif

    // Handshake, bit-serial conversion and registered result outputs.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            bcd_work  <= '0;
            cnt       <= '0;
            ovf_work  <= 1'b0;
            bcd       <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
            blank     <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift_reg <= bin;
                        bcd_work  <= '0;
                        cnt       <= CNT_W'(BIN_W);
                        ovf_work  <= (64'(bin) >= LIMIT);
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_work  <= next_work;
                    shift_reg <= {shift_reg[BIN_W-2:0], 1'b0};
                    cnt       <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state     <= IDLE;
                        out_valid <= 1'b1;
                        overflow  <= ovf_work;
                        bcd       <= ovf_work ? SAT : next_work;
`ifdef BIN2BCD_BLANK_EN
                        blank     <= ovf_work ? '0 : blank_next;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential shift-and-add-3 (double-dabble) binary-to-BCD converter.
- Sits upstream of the 4-digit seven-segment display driver and supplies its decimal-mode data bus from a binary count or measurement.
- Uses a valid/ready input handshake and produces a one-cycle result strobe.
- Result is held stable between conversions, so the display may sample it at any time.

Parameters:
- BIN_W, 14, width of the binary input (14 bits covers 0..16383).
- DIGITS, 4, number of BCD output digits; the localparam LIMIT = 10^DIGITS is computed at elaboration.

Ports:
- clk  input  1  conversion clock (divided system clock).
- rst_n  input  1  asynchronous active-low reset.
- bin  input  BIN_W  unsigned binary value, sampled on the handshake edge.
- in_valid  input  1  request to convert bin.
- in_ready  output  1  high when the block accepts a new value.
- bcd  output  4*DIGITS  packed BCD result; digit 0 is in bits [3:0].
- out_valid  output  1  one-cycle strobe marking a new bcd value.
- overflow  output  1  high when the last accepted bin was >= LIMIT; held with bcd.
- blank  output  DIGITS  leading-zero mask, one bit per digit (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): state=IDLE, bcd=0, out_valid=0, overflow=0, blank=0, internal shift/BCD registers=0, bit counter=0.
- Reset release: takes effect on the next clk edge.
- States: IDLE, SHIFT.
- in_ready = (state==IDLE), combinational from the state register.
- Handshake edge E0 (in_valid && in_ready):
  - Latch bin into the shift register.
  - Clear the BCD working register.
  - Counter = BIN_W.
  - Capture the overflow flag = (bin >= LIMIT).
  - State -> SHIFT.
- SHIFT, one bit per edge:
  - Each BCD nibble >= 5 gets +3.
  - Then {bcd_work, shift} is shifted left by 1.
  - Counter decrements.
- Edge E_BIN_W (counter reaches 1 -> 0):
  - State -> IDLE.
  - bcd <= working value, or all 4'h9 digits if overflow is set (saturation).
  - overflow output updated.
  - out_valid <= 1 for exactly one cycle.
- Latency: out_valid is high in the cycle after edge E0 + BIN_W. Default: 14 cycles after acceptance.
- Back-to-back: in_ready is high in the same cycle as out_valid. A new request accepted there starts immediately; throughput is one result per BIN_W+1 cycles.
- in_valid while busy: ignored (in_ready=0). The bin value is not captured, there is no queueing, and the current conversion is unaffected.
- bcd/overflow/blank change only on the out_valid edge; they are stable otherwise.
- Working-register width: 4*DIGITS bits. Overflowed bits beyond the top nibble are discarded; the saturation path covers correctness.
- rst_n asserted mid-SHIFT: conversion aborted, all outputs return to reset values, and no out_valid is ever issued for the aborted request.
- bin=0: result all zeros, overflow=0.
- bin=LIMIT-1: all 9s, overflow=0.

Optional Feature:
- Macro: BIN2BCD_BLANK_EN.
- Defined:
  - blank[i]=1 when digit i and every higher digit are 0, for i >= 1.
  - blank[0] is always 0.
  - Updated together with bcd on the out_valid edge.
  - All zeros when overflow=1.
- Not defined: blank is tied to 0 and no blanking logic is synthesised.

Test Plan:
- Reset, then bin=1234 (0x04D2) with one-cycle in_valid -> in_ready=0 for 14 cycles, out_valid pulse with bcd=16'h1234, overflow=0, in_ready=1 in the same cycle.
- bin=0, then bin=9999 -> bcd=16'h0000 and 16'h9999 respectively, overflow=0 both.
- bin=10000 and bin=16383 -> bcd=16'h9999, overflow=1 each; with the macro defined, blank=4'b0000.
- in_valid held high continuously with bin stepping 1,2,3 -> results 0x0001, 0x0002, 0x0003 exactly 15 cycles apart; bin changes while busy are not captured.
- rst_n pulsed low at cycle 7 of the conversion of 4321 -> outputs zero immediately, no out_valid; a later conversion of 4321 yields 16'h4321.
- BIN2BCD_BLANK_EN defined, bin=42 -> bcd=16'h0042, blank=4'b1100. Then bin=0 -> blank=4'b1110. Without the macro, blank=0 in both cases.
